sid_envelope: RTL and testbench

ADSR envelope generator and VCA: the consumer end of the voice-parameter interface that the drum/bass sequencer drives. It takes a gate plus packed attack/decay and sustain/release nibbles and produces an 8-bit envelope. The envelope scales an incoming 8-bit unsigned waveform sample, and the result feeds the voice mixer. One instance is placed per voice.

---
 rtl/sid_envelope_if.sv | 13 +
 rtl/sid_envelope.sv | 64 ++++++
 tb/tb_sid_envelope.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sid_envelope_if.sv
// sid_envelope_if: voice-parameter bus from the sequencer into one envelope/VCA voice.
interface sid_envelope_if;
  logic       gate;
  logic [7:0] attack_decay;
  logic [7:0] sustain_release;
  logic [7:0] audio_in;
  logic [7:0] env;
  logic [2:0] state;
  logic       busy;
  logic [7:0] audio_out;
  modport master(output gate, attack_decay, sustain_release, audio_in, input env, state, busy, audio_out);
  modport slave(input gate, attack_decay, sustain_release, audio_in, output env, state, busy, audio_out);
endinterface

// File: rtl/sid_envelope.sv
// sid_envelope: ADSR envelope generator with an 8-bit VCA on the waveform sample.
module sid_envelope #(
  parameter int RATE_BASE = 16
) (
  input logic clk,
  input logic rst_n,
  sid_envelope_if.slave bus
);
  localparam int CW = $clog2(RATE_BASE) + 15;
  localparam logic [2:0] IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4;
  logic [2:0] st, nxt;
  logic [7:0] env, env_n, lvl, aout;
  logic [CW-1:0] cnt, lim;
  logic [3:0] rate;
  logic gate_q, rise, run, tick;
  assign rise = bus.gate & ~gate_q;
  assign lvl = {2{bus.sustain_release[3:0]}};
  assign rate = st == ATTACK ? bus.attack_decay[3:0] : st == DECAY ? bus.attack_decay[7:4] : bus.sustain_release[7:4];
  assign lim = (CW'(RATE_BASE) << rate) - CW'(1);
  assign run = st == ATTACK || st == DECAY || st == RELEASE;
  assign tick = run && cnt == lim;
  always_comb begin
    nxt = st;
    env_n = env;
    case (st)
      IDLE: if (rise) nxt = ATTACK;
      ATTACK:
        if (!bus.gate) nxt = RELEASE;
        else if (tick) begin
          env_n = env == 8'hff ? env : env + 8'd1;
          if (env >= 8'hfe) nxt = DECAY;
        end
      DECAY:
        if (!bus.gate) nxt = RELEASE;
        else if (env <= lvl) nxt = SUSTAIN;
        else if (tick) env_n = env - 8'd1;
      SUSTAIN: if (!bus.gate) nxt = RELEASE;
      RELEASE:
        if (rise) nxt = ATTACK;
        else if (env == 8'd0) nxt = IDLE;
        else if (tick) env_n = env - 8'd1;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
      st <= IDLE;
      env <= 8'd0;
      cnt <= '0;
      aout <= 8'd0;
    end else begin
      gate_q <= bus.gate;
      st <= nxt;
      env <= env_n;
      cnt <= (nxt != st || !run || tick) ? '0 : cnt + CW'(1);
      aout <= 8'((16'(bus.audio_in) * 16'(env)) >> 8);
    end
  end
  assign bus.env = env;
  assign bus.state = st;
  assign bus.busy = st != IDLE;
  assign bus.audio_out = aout;
endmodule

// File: tb/tb_sid_envelope.sv
// tb_sid_envelope: table-driven ADSR timing checks plus hand-written retrigger, reset and VCA sequences.
module tb_sid_envelope;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sid_envelope_if bus();
  sid_envelope #(.RATE_BASE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct { int at; logic [7:0] env; logic [2:0] st; logic gate_next; } vec_t;
  typedef struct { logic [7:0] a; logic [7:0] y; } vca_t;
  int checks = 0;
  int errors = 0;
  int ed;
  vec_t adsr[14];
  vca_t vca255[4];
  vca_t vca128[4];
  vec_t sb[$];
  logic [7:0] aq[$];
  vec_t v;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, ed, act, exp);
    end
  endtask
  task automatic chk_env(input string nm, input logic [7:0] e, input logic [2:0] s);
    chk({nm, ".env"}, 16'(bus.env), 16'(e));
    chk({nm, ".state"}, 16'(bus.state), 16'(s));
    chk({nm, ".busy"}, 16'(bus.busy), 16'(s != 3'd0));
  endtask
  task automatic adv(input int target);
    while (ed < target) begin
      @(posedge clk);
      #1;
      ed++;
    end
  endtask
  task automatic do_reset(input logic [7:0] ad, input logic [7:0] sr);
    rst_n = 1'b0;
    bus.attack_decay = ad;
    bus.sustain_release = sr;
    bus.gate = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ed = -1;
  endtask
  task automatic vca(input logic [7:0] a, input logic [7:0] y);
    bus.audio_in = a;
    aq.push_back(y);
    adv(ed + 1);
    chk("vca", 16'(bus.audio_out), 16'(aq.pop_front()));
  endtask
  initial begin
    adsr = '{'{0, 8'h00, 3'd1, 1'b1}, '{1, 8'h01, 3'd1, 1'b1}, '{254, 8'hfe, 3'd1, 1'b1},
             '{255, 8'hff, 3'd2, 1'b1}, '{270, 8'hff, 3'd2, 1'b1}, '{271, 8'hfe, 3'd2, 1'b1},
             '{2703, 8'h66, 3'd2, 1'b1}, '{2704, 8'h66, 3'd3, 1'b1}, '{2800, 8'h66, 3'd3, 1'b0},
             '{2801, 8'h66, 3'd4, 1'b0}, '{2928, 8'h66, 3'd4, 1'b0}, '{2929, 8'h65, 3'd4, 1'b0},
             '{15857, 8'h00, 3'd4, 1'b0}, '{15858, 8'h00, 3'd0, 1'b0}};
    vca255 = '{'{8'd255, 8'd254}, '{8'd128, 8'd127}, '{8'd1, 8'd0}, '{8'd0, 8'd0}};
    vca128 = '{'{8'd200, 8'd100}, '{8'd255, 8'd127}, '{8'd3, 8'd1}, '{8'd0, 8'd0}};
    bus.gate = 1'b0;
    bus.attack_decay = 8'h00;
    bus.sustain_release = 8'h00;
    bus.audio_in = 8'd0;
    ed = 0;
    @(posedge clk);
    #1;
    chk_env("reset", 8'h00, 3'd0);
    chk("reset.audio_out", 16'(bus.audio_out), 16'd0);
    // Attack, decay to 0x66, sustain, then release back to idle
    do_reset(8'h40, 8'h76);
    foreach (adsr[i]) sb.push_back(adsr[i]);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      adv(v.at);
      chk_env("adsr", v.env, v.st);
      bus.gate = v.gate_next;
    end
    // Retrigger from release at env 50 continues upward from 50
    do_reset(8'h00, 8'h03);
    adv(459);
    chk_env("retrig.decay", 8'd51, 3'd2);
    adv(460);
    chk_env("retrig.sustain", 8'd51, 3'd3);
    bus.gate = 1'b0;
    adv(462);
    chk_env("retrig.release", 8'd50, 3'd4);
    bus.gate = 1'b1;
    bus.attack_decay = 8'h02;
    adv(463);
    chk_env("retrig.attack", 8'd50, 3'd1);
    adv(466);
    chk_env("retrig.wait", 8'd50, 3'd1);
    adv(467);
    chk_env("retrig.step", 8'd51, 3'd1);
    // Sustain level 0xF: decay lasts a single edge at 255
    do_reset(8'h00, 8'h0f);
    bus.audio_in = 8'd0;
    adv(255);
    chk_env("sus_f.decay", 8'hff, 3'd2);
    adv(256);
    chk_env("sus_f.sustain", 8'hff, 3'd3);
    adv(300);
    chk_env("sus_f.hold", 8'hff, 3'd3);
    foreach (vca255[i]) vca(vca255[i].a, vca255[i].y);
    // Sustain captured at 128 by raising the level mid-decay, then held after the level drops
    do_reset(8'h00, 8'h00);
    adv(382);
    chk_env("hold.decay", 8'd128, 3'd2);
    bus.sustain_release = 8'h08;
    adv(383);
    chk_env("hold.sustain", 8'd128, 3'd3);
    bus.sustain_release = 8'h00;
    adv(390);
    chk_env("hold.live", 8'd128, 3'd3);
    foreach (vca128[i]) vca(vca128[i].a, vca128[i].y);
    // Asynchronous reset mid-attack
    do_reset(8'h00, 8'h00);
    bus.audio_in = 8'd200;
    adv(40);
    chk_env("async.pre", 8'd40, 3'd1);
    chk("async.pre.audio_out", 16'(bus.audio_out), 16'd30);
    #2;
    rst_n = 1'b0;
    #1;
    chk_env("async", 8'd0, 3'd0);
    chk("async.audio_out", 16'(bus.audio_out), 16'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_env("async.held", 8'd0, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
